// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and constants for the transmit path
// Holds the feeder FSM state type, the data width and the baud divisor used by the transmitter.
package uart_pkg;
    localparam int UART_DATA_W  = 8;
    localparam int CLKS_PER_BIT = 4;
    typedef enum logic [1:0] {IDLE, WAIT_DONE, GAP} feeder_state_t;
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: synchronous FIFO with occupancy count and synchronous flush
// Ports: i_clk/i_rst_n clock and async active-low reset, i_flush clears contents,
// i_wr_en/i_wr_data push (ignored when full or flushing), i_rd_en pop (ignored when empty),
// o_rd_data head entry, o_count/o_empty/o_full occupancy.
module uart_sync_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_flush,
    input  logic                    i_wr_en,
    input  logic [DATA_W-1:0]       i_wr_data,
    input  logic                    i_rd_en,
    output logic [DATA_W-1:0]       o_rd_data,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic                    o_empty,
    output logic                    o_full
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic wr_ok, rd_ok;
    assign wr_ok     = i_wr_en && !o_full && !i_flush;
    assign rd_ok     = i_rd_en && !o_empty;
    assign o_rd_data = mem[rd_ptr];
    assign o_empty   = o_count == '0;
    assign o_full    = o_count == (AW+1)'(DEPTH);
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_count <= '0;
        end else if (i_flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_count <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            o_count <= (wr_ok && !rd_ok) ? o_count + 1'b1 : (rd_ok && !wr_ok) ? o_count - 1'b1 : o_count;
        end
    end
    always_ff @(posedge i_clk) begin
        if (wr_ok) mem[wr_ptr] <= i_wr_data;
    end
endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: buffers producer bytes and hands them one at a time to the UART transmitter
// Ports: i_clk/i_rst_n clock and async active-low reset, i_flush clears queued bytes,
// i_wr_valid/i_wr_byte/o_wr_ready producer handshake, o_tx_dv/o_tx_byte one-cycle strobe and
// held byte to the transmitter, i_tx_active/i_tx_done transmitter status,
// o_count/o_empty/o_full queue occupancy, o_busy queue non-empty or byte in progress.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int GAP_CLKS = 0
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_flush,
    input  logic                    i_wr_valid,
    input  logic [UART_DATA_W-1:0]  i_wr_byte,
    output logic                    o_wr_ready,
    output logic                    o_tx_dv,
    output logic [UART_DATA_W-1:0]  o_tx_byte,
    input  logic                    i_tx_active,
    input  logic                    i_tx_done,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic                    o_empty,
    output logic                    o_full,
    output logic                    o_busy
);
    localparam int GW = GAP_CLKS > 1 ? $clog2(GAP_CLKS) : 1;
    feeder_state_t state_q, state_d;
    logic [GW-1:0] gap_q, gap_d;
    logic pop;
    logic [UART_DATA_W-1:0] head;
    uart_sync_fifo #(.DEPTH(DEPTH), .DATA_W(UART_DATA_W)) u_fifo (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_flush   (i_flush),
        .i_wr_en   (i_wr_valid),
        .i_wr_data (i_wr_byte),
        .i_rd_en   (pop),
        .o_rd_data (head),
        .o_count   (o_count),
        .o_empty   (o_empty),
        .o_full    (o_full)
    );
    assign o_wr_ready = !o_full;
    assign o_busy     = !o_empty || state_q != IDLE;
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!o_empty && !i_tx_active) begin
                    pop     = 1'b1;
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (i_tx_done) begin
                    state_d = GAP_CLKS == 0 ? IDLE : GAP;
                    gap_d   = GW'(GAP_CLKS > 0 ? GAP_CLKS - 1 : 0);
                end
            end
            GAP: begin
                gap_d   = gap_q == '0 ? '0 : gap_q - 1'b1;
                state_d = gap_q == '0 ? IDLE : GAP;
            end
            default: state_d = IDLE;
        endcase
    end
    // The strobe is taken from pop directly, so a flush on the issue edge still lets the byte out.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            gap_q     <= '0;
            o_tx_dv   <= 1'b0;
            o_tx_byte <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            o_tx_dv <= pop;
            if (pop) o_tx_byte <= head;
        end
    end
endmodule
